// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
// gpr_pkg : write-mode encodings and saturating adder shared by the GPR file
// Revision: 1.0
// ============================================================================
package gpr_pkg;

    localparam logic [1:0] WMODE_LOAD  = 2'b00;
    localparam logic [1:0] WMODE_INCR  = 2'b01;
    localparam logic [1:0] WMODE_ACC   = 2'b10;
    localparam logic [1:0] WMODE_CLEAR = 2'b11;

    localparam int GPR_MAX_W = 64;

    // Operands must be zero above bit width-1 so that sum[width] is the true carry.
    function automatic logic [GPR_MAX_W-1:0] sat_add(
        input logic [GPR_MAX_W-1:0] a,
        input logic [GPR_MAX_W-1:0] b,
        input logic [6:0]           width,
        input logic                 sat
    );
        logic [GPR_MAX_W:0]   sum;
        logic [GPR_MAX_W-1:0] mask;
        sum  = {1'b0, a} + {1'b0, b};
        mask = {GPR_MAX_W{1'b1}} >> (7'(GPR_MAX_W) - width);
        if (sat && sum[width]) begin
            sat_add = mask;
        end else begin
            sat_add = sum[GPR_MAX_W-1:0] & mask;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_write_alu.sv
`default_nettype none
// ============================================================================
// rf_write_alu : combinational next-value logic for one modal register write
// Revision: 1.0
// ============================================================================
module rf_write_alu
    import gpr_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SAT_ACC = 0
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [1:0]       wmode_i,
    output logic [WIDTH-1:0] next_o
);

    logic [GPR_MAX_W-1:0] w_cur_ext;
    logic [GPR_MAX_W-1:0] w_wdata_ext;

    always_comb begin
        w_cur_ext                = '0;
        w_cur_ext[WIDTH-1:0]     = cur_i;
        w_wdata_ext              = '0;
        w_wdata_ext[WIDTH-1:0]   = wdata_i;
    end

    always_comb begin
        next_o = '0;
        case (wmode_i)
            WMODE_LOAD:  next_o = wdata_i;
            WMODE_INCR:  next_o = cur_i + WIDTH'(1);
            WMODE_ACC:   next_o = WIDTH'(sat_add(w_cur_ext, w_wdata_ext, 7'(WIDTH), SAT_ACC != 0));
            default:     next_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gp_register_file.sv
`default_nettype none
// ============================================================================
// gp_register_file : DEPTH-entry GPR file, one modal write port, two registered reads
// Revision: 1.0
// ============================================================================
module gp_register_file
    import gpr_pkg::*;
#(
    parameter int  WIDTH    = 16,
    parameter int  DEPTH    = 8,
    parameter int  SAT_ACC  = 0,
    parameter int  ZERO_REG = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        wmode,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_b,
    output logic              addr_err
);

    localparam bit c_POW2 = (DEPTH == (1 << ADDR_W));
    localparam bit c_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] rdata_a_q, rdata_b_q;
    logic             rvalid_a_q, rvalid_b_q, addr_err_q;

    logic [WIDTH-1:0] w_cur, w_next, w_rd_a, w_rd_b;
    logic             w_waddr_bad, w_raddr_a_bad, w_raddr_b_bad, w_wr_en;

    // Out-of-range addresses only exist when DEPTH leaves unused codes.
    if (c_POW2) begin : g_full_addr
        assign w_waddr_bad   = 1'b0;
        assign w_raddr_a_bad = 1'b0;
        assign w_raddr_b_bad = 1'b0;
    end else begin : g_partial_addr
        localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);
        assign w_waddr_bad   = (waddr   > c_LAST);
        assign w_raddr_a_bad = (raddr_a > c_LAST);
        assign w_raddr_b_bad = (raddr_b > c_LAST);
    end

    assign w_wr_en = we && !w_waddr_bad && !(c_ZERO && (waddr == '0));

    always_comb begin
        w_cur = '0;
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (waddr   == ADDR_W'(i)) w_cur  = regs_q[i];
            if (raddr_a == ADDR_W'(i)) w_rd_a = regs_q[i];
            if (raddr_b == ADDR_W'(i)) w_rd_b = regs_q[i];
        end
        // Bypass a same-cycle write, then force zero for bad or hard-wired-zero reads.
        if (w_wr_en && (waddr == raddr_a)) w_rd_a = w_next;
        if (w_wr_en && (waddr == raddr_b)) w_rd_b = w_next;
        if (w_raddr_a_bad || (c_ZERO && (raddr_a == '0))) w_rd_a = '0;
        if (w_raddr_b_bad || (c_ZERO && (raddr_b == '0))) w_rd_b = '0;
    end

    rf_write_alu #(
        .WIDTH   (WIDTH),
        .SAT_ACC (SAT_ACC)
    ) u_alu (
        .cur_i   (w_cur),
        .wdata_i (wdata),
        .wmode_i (wmode),
        .next_o  (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en && (waddr == ADDR_W'(i))) regs_q[i] <= w_next;
            end
            if (re_a) rdata_a_q <= w_rd_a;
            if (re_b) rdata_b_q <= w_rd_b;
            rvalid_a_q <= re_a;
            rvalid_b_q <= re_b;
            addr_err_q <= (we && w_waddr_bad) || (re_a && w_raddr_a_bad) ||
                          (re_b && w_raddr_b_bad);
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign addr_err = addr_err_q;

endmodule
`default_nettype wire
